// File: rtl/huffman_decoder.sv
// huffman_decoder: latches a six-entry Huffman code/mask table and decodes a
// serial bitstream into symbol indices 1..6, with one-cycle sym/err strobes.
module huffman_decoder #(
   parameter int unsigned MAXLEN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       code_valid,
   input  logic [7:0] HC1,
   input  logic [7:0] HC2,
   input  logic [7:0] HC3,
   input  logic [7:0] HC4,
   input  logic [7:0] HC5,
   input  logic [7:0] HC6,
   input  logic [7:0] M1,
   input  logic [7:0] M2,
   input  logic [7:0] M3,
   input  logic [7:0] M4,
   input  logic [7:0] M5,
   input  logic [7:0] M6,
   input  logic       bit_valid,
   input  logic       bit_in,
   output logic       table_ready,
   output logic       sym_valid,
   output logic [2:0] sym,
   output logic       err
);

   typedef enum logic [0:0] {StIdle, StDecode} state_e;

   state_e state_q, state_d;

   logic [7:0]        hc_in [6];
   logic [7:0]        m_in  [6];
   logic [7:0]        hc_q  [6];
   logic [7:0]        m_q   [6];
   logic [3:0]        len_q [6];
   logic [5:0]        en_q;
   logic [3:0]        len_new [6];
   logic [5:0]        en_new;

   logic [MAXLEN-1:0] acc_q, acc_d, acc_n;
   logic [3:0]        cnt_q, cnt_d, cnt_n;
   logic [2:0]        sym_q, sym_d;
   logic              sym_valid_q, sym_valid_d;
   logic              err_q, err_d;
   logic [5:0]        match;
   logic              found;
   logic [2:0]        found_idx;

   assign hc_in[0] = HC1;
   assign hc_in[1] = HC2;
   assign hc_in[2] = HC3;
   assign hc_in[3] = HC4;
   assign hc_in[4] = HC5;
   assign hc_in[5] = HC6;
   assign m_in[0]  = M1;
   assign m_in[1]  = M2;
   assign m_in[2]  = M3;
   assign m_in[3]  = M4;
   assign m_in[4]  = M5;
   assign m_in[5]  = M6;

   // Code length and enable per incoming mask; a mask is usable only if it is
   // a nonzero run of ones starting at bit 0 (m & (m+1) == 0).
   always_comb begin
      for (int k = 0; k < 6; k++) begin
         len_new[k] = 4'($countones(m_in[k]));
         en_new[k]  = (m_in[k] != 8'd0) && ((m_in[k] & 8'(m_in[k] + 8'd1)) == 8'd0);
      end
   end

   // Table registers, loaded on every code_valid edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 6; k++) begin
            hc_q[k]  <= 8'd0;
            m_q[k]   <= 8'd0;
            len_q[k] <= 4'd0;
         end
         en_q <= 6'd0;
      end else if (code_valid) begin
         for (int k = 0; k < 6; k++) begin
            hc_q[k]  <= hc_in[k];
            m_q[k]   <= m_in[k];
            len_q[k] <= len_new[k];
         end
         en_q <= en_new;
      end
   end

   // Match each enabled symbol against the accumulator including the new bit.
   always_comb begin
      acc_n = {acc_q[MAXLEN-2:0], bit_in};
      cnt_n = cnt_q + 4'd1;
      for (int k = 0; k < 6; k++) begin
         match[k] = en_q[k] && (len_q[k] == cnt_n) &&
                    ((acc_n & m_q[k]) == (hc_q[k] & m_q[k]));
      end
   end

   // Lowest-index match wins.
   always_comb begin
      found     = 1'b0;
      found_idx = 3'd0;
      for (int k = 0; k < 6; k++) begin
         if (!found && match[k]) begin
            found     = 1'b1;
            found_idx = 3'(k + 1);
         end
      end
   end

   // Next-state: reload takes precedence over a coincident bit.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sym_d       = sym_q;
      sym_valid_d = 1'b0;
      err_d       = 1'b0;
      if (code_valid) begin
         state_d = StDecode;
         acc_d   = '0;
         cnt_d   = 4'd0;
      end else if ((state_q == StDecode) && bit_valid) begin
         if (found) begin
            sym_d       = found_idx;
            sym_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = 4'd0;
         end else if (cnt_n == 4'(MAXLEN)) begin
            err_d = 1'b1;
            acc_d = '0;
            cnt_d = 4'd0;
         end else begin
            acc_d = acc_n;
            cnt_d = cnt_n;
         end
      end
   end

   // State, accumulator and output strobe registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         cnt_q       <= 4'd0;
         sym_q       <= 3'd0;
         sym_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sym_q       <= sym_d;
         sym_valid_q <= sym_valid_d;
         err_q       <= err_d;
      end
   end

   assign table_ready = (state_q == StDecode);
   assign sym_valid   = sym_valid_q;
   assign sym         = sym_q;
   assign err         = err_q;

endmodule
